rolling_mark_board: RTL
=======================

# rolling_mark_board

Parametrised board-state keeper for the rolling-mark (“vanishing piece”) tic-tac-toe family. It generalises the two-player, 9-cell, fixed-history marker to any cell count, player count and live-mark depth. Each player keeps at most DEPTH marks on the board; placing one more evicts that player’s oldest mark in the same cycle. It sits between the input/turn controller (move requests) and the win checker and display (board and eviction-preview outputs). It validates every move and returns a one-cycle response code.

## Interface
- CELLS, 9: number of board cells, 2..64.
- PLAYERS, 2: number of players, 2..4.
- DEPTH, 3: maximum live marks per player, 1..8.
- Derived widths:
  - AW = max(1, clog2(CELLS))
  - CW = clog2(PLAYERS+1)
  - PW = max(1, clog2(PLAYERS))
  - DW = clog2(DEPTH+1)
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous game restart; has priority over any move.
- move_valid  in  1  move request present.
- move_ready  out  1  = ~clear; move is accepted when move_valid & move_ready.
- move_player  in  PW  requesting player index.
- move_pos  in  AW  target cell index.
- resp_valid  out  1  one-cycle pulse, one per accepted request.
- resp_code  out  2  result: 00 OK, 01 RANGE, 10 TURN, 11 OCCUPIED.
- turn  out  PW  player expected to move next.
- board  out  CELLS*CW  cell i at [i*CW +: CW]; 0 = empty, p+1 = player p.
- live_cnt  out  PLAYERS*DW  live marks of player p at [p*DW +: DW].
- oldest_pos  out  PLAYERS*AW  cell of player p’s oldest live mark; 0 when live_cnt is 0.
- evict_next  out  PLAYERS  bit p = (live_cnt[p] == DEPTH): p’s oldest mark vanishes on p’s next successful move.

## Operation
- **Reset values (rst low):** board all 0, turn 0, all live_cnt 0, oldest_pos 0, evict_next 0, resp_valid 0, resp_code 00. Per-player queue head/tail pointers are 0.
- **clear:** returns all of the above to their reset values at the next edge. move_ready is low while clear is high, so no request is accepted and no response is produced in that cycle.
- **State per player:** a circular queue of DEPTH cell indices with head, tail and count, plus a shared turn counter.
- **Validation of an accepted request**, checked in priority order:
  1. move_pos >= CELLS gives RANGE.
  2. move_player != turn gives TURN.
  3. board[move_pos] != 0 gives OCCUPIED. This includes the player’s own oldest mark, even though it would be evicted.
- A rejected move changes no state other than resp_valid and resp_code.
- **OK move by player p:**
  - board[move_pos] becomes p+1.
  - move_pos is enqueued at p’s tail.
  - If live_cnt[p] == DEPTH, the head entry is dequeued in the same edge and that cell is written 0. Count stays at DEPTH.
  - Otherwise count increments.
  - turn becomes (turn+1) mod PLAYERS.
- The evicted cell never equals move_pos, because occupied targets are rejected. Add + remove therefore never collide.
- **Queue wrap:** pointers wrap from DEPTH-1 to 0. DEPTH=1 degenerates to single-mark replacement.
- The queue never overflows and never underflows. A dequeue occurs only together with an enqueue, and only when full.
- oldest_pos tracks the queue head combinationally from registered state.

## Timing
- Accept at edge N: board, turn, live_cnt, oldest_pos and evict_next show the new state after edge N. resp_valid is high for the cycle following edge N.
- Throughput is one move per cycle. Back-to-back accepts produce back-to-back resp_valid pulses. There is no stall other than clear.
- move_ready depends combinationally on clear only. There is no path from move_valid to move_ready.
- Asynchronous reset asserted mid-game immediately forces the reset values. Any in-flight response is discarded; resp_valid drops at once.
- clear and move_valid high together: clear wins, the request is ignored, and the requester must re-present it.

## Test plan
- **Reset and defaults:** with default params, release rst and present no request → board 0, turn 0, move_ready 1, evict_next 00.
- **Eviction:** play P0:0, P1:1, P0:2, P1:3, P0:4, P1:5, P0:6.
  - Before the P0:6 move, evict_next[0] = 1 and oldest_pos[0] = 0.
  - After it, cell 0 = 0, cell 6 = 1, live_cnt[0] = 3, oldest_pos[0] = 2, resp_code 00.
- **Errors:**
  - pos=9 gives resp 01.
  - P1 moving on P0’s turn gives 10.
  - P0 targeting its own oldest cell gives 11.
  - In all three cases board and turn are unchanged.
- **Priority:** P1 out of turn with pos=12 → resp 01, not 10.
- **Clear collision:** clear and move_valid high in the same cycle → no resp_valid, board all 0 next cycle, turn 0.
- **Parametric run:** CELLS=16, PLAYERS=3, DEPTH=2, 12 rotating legal moves.
  - Turn cycles 0,1,2.
  - Each player holds exactly 2 marks after move 6.
  - Queue pointers wrap correctly, checked against the reference-model board every cycle.
  - Mid-run rst low → immediate all-zero outputs.

Source files
------------

// File: rtl/rolling_mark_board.sv
`default_nettype none
// ============================================================================
// Module : rolling_mark_board
// Brief  : Board keeper for rolling-mark tic-tac-toe; each player holds at
//          most DEPTH marks and the oldest one vanishes on overflow.
// Rev    : 1.0  initial release
// ============================================================================
module rolling_mark_board #(
  parameter int CELLS   = 9,
  parameter int PLAYERS = 2,
  parameter int DEPTH   = 3,
  localparam int AW = (CELLS > 1) ? $clog2(CELLS) : 1,
  localparam int CW = $clog2(PLAYERS + 1),
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_move_valid,
  output logic                  o_move_ready,
  input  logic [PW-1:0]         i_move_player,
  input  logic [AW-1:0]         i_move_pos,
  output logic                  o_resp_valid,
  output logic [1:0]            o_resp_code,
  output logic [PW-1:0]         o_turn,
  output logic [CELLS*CW-1:0]   o_board,
  output logic [PLAYERS*DW-1:0] o_live_cnt,
  output logic [PLAYERS*AW-1:0] o_oldest_pos,
  output logic [PLAYERS-1:0]    o_evict_next
);

  localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    c_cells       = (AW + 1)'(CELLS);
  localparam logic [DW-1:0]  c_depth       = DW'(DEPTH);
  localparam logic [PW-1:0]  c_last_player = PW'(PLAYERS - 1);
  localparam logic [QW-1:0]  c_last_slot   = QW'(DEPTH - 1);

  localparam logic [1:0] c_RESP_OK    = 2'b00;
  localparam logic [1:0] c_RESP_RANGE = 2'b01;
  localparam logic [1:0] c_RESP_TURN  = 2'b10;
  localparam logic [1:0] c_RESP_OCC   = 2'b11;

  logic [CW-1:0] r_board [CELLS];
  logic [AW-1:0] r_q     [PLAYERS][DEPTH];
  logic [QW-1:0] r_head  [PLAYERS];
  logic [QW-1:0] r_tail  [PLAYERS];
  logic [DW-1:0] r_cnt   [PLAYERS];
  logic [PW-1:0] r_turn;
  logic          r_resp_valid;
  logic [1:0]    r_resp_code;

  logic          w_accept;
  logic          w_range;
  logic          w_turn_err;
  logic          w_occupied;
  logic [1:0]    w_code;
  logic          w_ok;
  logic          w_full;
  logic [AW-1:0] w_evict_pos;
  logic [CW-1:0] w_mark;

  function automatic logic [QW-1:0] f_next_slot(input logic [QW-1:0] slot);
    return (slot == c_last_slot) ? '0 : slot + QW'(1);
  endfunction

  assign o_move_ready = ~i_clear;
  assign w_accept     = i_move_valid & ~i_clear;
  assign w_range      = {1'b0, i_move_pos} >= c_cells;
  assign w_turn_err   = i_move_player != r_turn;
  // Only meaningful when w_range is low; the priority mux below guarantees that.
  assign w_occupied   = r_board[i_move_pos] != '0;
  assign w_full       = r_cnt[r_turn] == c_depth;
  assign w_evict_pos  = r_q[r_turn][r_head[r_turn]];
  assign w_mark       = CW'(r_turn) + CW'(1);
  assign w_ok         = w_accept & (w_code == c_RESP_OK);

  always_comb begin
    w_code = c_RESP_OK;
    if (w_range)         w_code = c_RESP_RANGE;
    else if (w_turn_err) w_code = c_RESP_TURN;
    else if (w_occupied) w_code = c_RESP_OCC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_turn       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_code  <= c_RESP_OK;
      for (int c = 0; c < CELLS; c++) r_board[c] <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        r_head[p] <= '0;
        r_tail[p] <= '0;
        r_cnt[p]  <= '0;
        for (int d = 0; d < DEPTH; d++) r_q[p][d] <= '0;
      end
    end else if (i_clear) begin
      r_turn       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_code  <= c_RESP_OK;
      for (int c = 0; c < CELLS; c++) r_board[c] <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        r_head[p] <= '0;
        r_tail[p] <= '0;
        r_cnt[p]  <= '0;
        for (int d = 0; d < DEPTH; d++) r_q[p][d] <= '0;
      end
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) r_resp_code <= w_code;
      if (w_ok) begin
        // Evicted cell can never be the target: occupied targets are rejected.
        if (w_full) begin
          r_board[w_evict_pos] <= '0;
          r_head[r_turn]       <= f_next_slot(r_head[r_turn]);
        end else begin
          r_cnt[r_turn] <= r_cnt[r_turn] + DW'(1);
        end
        r_board[i_move_pos]         <= w_mark;
        r_q[r_turn][r_tail[r_turn]] <= i_move_pos;
        r_tail[r_turn]              <= f_next_slot(r_tail[r_turn]);
        r_turn <= (r_turn == c_last_player) ? '0 : r_turn + PW'(1);
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_code  = r_resp_code;
  assign o_turn       = r_turn;

  generate
    for (genvar c = 0; c < CELLS; c++) begin : g_board
      assign o_board[c*CW +: CW] = r_board[c];
    end
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      assign o_live_cnt[p*DW +: DW]   = r_cnt[p];
      assign o_evict_next[p]          = r_cnt[p] == c_depth;
      assign o_oldest_pos[p*AW +: AW] = (r_cnt[p] == '0) ? '0 : r_q[p][r_head[p]];
    end
  endgenerate

endmodule
`default_nettype wire
